// File: rtl/sobel_pkg.sv
// Shared types, sizes and the sign-magnitude multiply-accumulate step for the Sobel convolver.
package sobel_pkg;

    localparam int unsigned PIX_BITS = 8;
    localparam int unsigned MAG_W    = 4;
    localparam int unsigned COEF_W   = MAG_W + 1;
    localparam int unsigned ACC_BITS = 18;
    localparam int unsigned NTAPS    = 9;
    localparam int unsigned TAP_W    = 4;
    localparam int unsigned EDGE_W   = 8;

    typedef logic [COEF_W-1:0]                  coef_t;
    typedef logic [PIX_BITS-1:0]                pix_t;
    typedef logic signed [ACC_BITS-1:0]         acc_t;
    typedef logic [2:0][2:0][PIX_BITS-1:0]      pix_win_t;
    typedef logic [2:0][2:0][COEF_W-1:0]        coef_win_t;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    // acc +/- pix*mag; the sign bit picks subtraction, so a negative zero adds nothing
    function automatic acc_t sm_mac(input acc_t acc, input pix_t pix, input coef_t coef);
        logic [PIX_BITS+MAG_W-1:0] prod;
        acc_t                      term;
        prod = (PIX_BITS+MAG_W)'(pix) * (PIX_BITS+MAG_W)'(coef[MAG_W-1:0]);
        term = acc_t'(prod);
        return coef[COEF_W-1] ? (acc - term) : (acc + term);
    endfunction

endpackage

// File: rtl/sobel_mac.sv
// Single signed accumulator applying one sign-magnitude tap per enabled cycle.
module sobel_mac
    import sobel_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  en,
    input  pix_t  pix,
    input  coef_t coef,
    output acc_t  acc,
    output acc_t  acc_nxt_c
);

    assign acc_nxt_c = sm_mac(acc, pix, coef);

    // accumulator register: clear on a new window, step on each tap
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_nxt_c;
        end
    end

endmodule

// File: rtl/sobel_convolver.sv
// Sequential 3x3 Sobel convolver: one tap per cycle, |Gx|+|Gy| scaled and clipped to 8 bits.
module sobel_convolver
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_BITS,
    parameter int unsigned ACC_W = ACC_BITS,
    parameter int unsigned SHIFT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0][2:0][PIX_W-1:0] win,
    input  coef_win_t                  kx,
    input  coef_win_t                  ky,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [EDGE_W-1:0]          edge_out,
    output logic                       sat
);

    localparam int unsigned      SUM_W    = ACC_W + 1;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAPS - 1);

    state_t                     state_q, state_d;
    logic [2:0][2:0][PIX_W-1:0] win_q;
    coef_win_t                  kx_q, ky_q;
    logic [TAP_W-1:0]           tap_q;
    logic                       load_c, step_c, fin_c;
    logic [1:0]                 row_c, col_c;
    pix_t                       pix_c;
    acc_t                       accx, accy, accx_nxt_c, accy_nxt_c;
    logic signed [SUM_W-1:0]    xs_c, ys_c;
    logic [SUM_W-1:0]           absx_c, absy_c, sum_c, shifted_c;
    logic [EDGE_W-1:0]          edge_c;
    logic                       sat_c;

    // next-state and control strobes
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        fin_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_c  = 1'b1;
                    state_d = ACC;
                end
            end
            ACC: begin
                step_c = 1'b1;
                if (tap_q == LAST_TAP) begin
                    fin_c   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tap mux: tap t selects row t/3, column t%3
    always_comb begin
        row_c = 2'(tap_q / TAP_W'(3));
        col_c = 2'(tap_q % TAP_W'(3));
        pix_c = pix_t'(win_q[row_c][col_c]);
    end

    sobel_mac u_mac_x (
        .clk       (clk),
        .rst       (rst),
        .clr       (load_c),
        .en        (step_c),
        .pix       (pix_c),
        .coef      (kx_q[row_c][col_c]),
        .acc       (accx),
        .acc_nxt_c (accx_nxt_c)
    );

    sobel_mac u_mac_y (
        .clk       (clk),
        .rst       (rst),
        .clr       (load_c),
        .en        (step_c),
        .pix       (pix_c),
        .coef      (ky_q[row_c][col_c]),
        .acc       (accy),
        .acc_nxt_c (accy_nxt_c)
    );

    // edge magnitude from the post-last-tap sums, so the result lands with the DONE entry
    always_comb begin
        xs_c      = SUM_W'(accx_nxt_c);
        ys_c      = SUM_W'(accy_nxt_c);
        absx_c    = xs_c[SUM_W-1] ? SUM_W'(-xs_c) : SUM_W'(xs_c);
        absy_c    = ys_c[SUM_W-1] ? SUM_W'(-ys_c) : SUM_W'(ys_c);
        sum_c     = absx_c + absy_c;
        shifted_c = sum_c >> SHIFT;
        edge_c    = EDGE_W'(shifted_c);
        sat_c     = 1'b0;
        if (shifted_c > SUM_W'(255)) begin
            edge_c = '1;
            sat_c  = 1'b1;
        end
    end

    // state, captured window/kernels, tap counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            win_q     <= '0;
            kx_q      <= '0;
            ky_q      <= '0;
            tap_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            edge_out  <= '0;
            sat       <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            if (load_c) begin
                win_q <= win;
                kx_q  <= kx;
                ky_q  <= ky;
                tap_q <= '0;
            end else if (step_c && !fin_c) begin
                tap_q <= tap_q + TAP_W'(1);
            end
            if (fin_c) begin
                edge_out <= edge_c;
                sat      <= sat_c;
            end
        end
    end

endmodule

// File: tb/tb_sobel_convolver.sv
// Directed bench for sobel_convolver; a SHIFT=0 twin runs in lockstep for the clipping cases.
module tb_sobel_convolver;
    import sobel_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready;
    pix_win_t    win;
    coef_win_t   kx, ky;
    logic        in_ready, out_valid, sat;
    logic [7:0]  edge_out;
    logic        in_ready0, out_valid0, sat0;
    logic [7:0]  edge_out0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sobel_convolver #(.SHIFT(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .win(win), .kx(kx), .ky(ky), .out_valid(out_valid), .out_ready(out_ready),
        .edge_out(edge_out), .sat(sat)
    );

    sobel_convolver #(.SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .win(win), .kx(kx), .ky(ky), .out_valid(out_valid0), .out_ready(out_ready),
        .edge_out(edge_out0), .sat(sat0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic coef_t sm(input int v);
        return (v < 0) ? {1'b1, 4'(-v)} : {1'b0, 4'(v)};
    endfunction

    function automatic coef_win_t mk_k(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        int t[9];
        coef_win_t k;
        t = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                k[r][c] = sm(t[3*r+c]);
        return k;
    endfunction

    function automatic pix_win_t mk_w(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        int t[9];
        pix_win_t w;
        t = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[r][c] = 8'(t[3*r+c]);
        return w;
    endfunction

    function automatic coef_win_t k_fill(input coef_t c);
        coef_win_t k;
        for (int r = 0; r < 3; r++)
            for (int q = 0; q < 3; q++)
                k[r][q] = c;
        return k;
    endfunction

    // present a window until accepted, then scramble the inputs (they must be ignored)
    task automatic launch(input string tag, input pix_win_t w, input coef_win_t x, input coef_win_t y);
        int n;
        win = w; kx = x; ky = y; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check_eq({tag, "_accept_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        win = ~w; kx = ~x; ky = ~y;
    endtask

    task automatic wait_result(input string tag, input int e2, input int s2, input int e0, input int s0);
        int lat;
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1; lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'd9);
        check_eq({tag, "_edge"}, 32'(edge_out), 32'(e2));
        check_eq({tag, "_sat"}, 32'(sat), 32'(s2));
        check_eq({tag, "_edge_s0"}, 32'(edge_out0), 32'(e0));
        check_eq({tag, "_sat_s0"}, 32'(sat0), 32'(s0));
        check_eq({tag, "_busy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq({tag, "_ready_after"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run(input string tag, input pix_win_t w, input coef_win_t x, input coef_win_t y,
                       input int e2, input int s2, input int e0, input int s0);
        launch(tag, w, x, y);
        wait_result(tag, e2, s2, e0, s0);
        release_out(tag);
    endtask

    coef_win_t sx, sy, kz, knz;
    pix_win_t  w_mix, w_r200, w_r100;
    pix_win_t  ws[3];
    coef_win_t xs[3], ys[3];
    int        acc_cyc[3];
    logic [7:0] res[3];
    logic       res_sat[3];
    int         dn, mn;

    initial begin
        sx     = mk_k(1, 0, -1, 2, 0, -2, 1, 0, -1);
        sy     = mk_k(1, 2, 1, 0, 0, 0, -1, -2, -1);
        kz     = k_fill(5'b00000);
        knz    = k_fill(5'b10000);
        w_mix  = mk_w(10, 20, 30, 40, 50, 60, 70, 80, 90);
        w_r200 = mk_w(0, 0, 200, 0, 0, 200, 0, 0, 200);
        w_r100 = mk_w(0, 0, 100, 0, 0, 100, 0, 0, 100);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        win = '0; kx = '0; ky = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_edge", 32'(edge_out), 32'd0);
        check_eq("rst_sat", 32'(sat), 32'd0);
        rst = 1'b0;

        // flat field, Sobel kernels: no edge
        run("uniform", mk_w(100, 100, 100, 100, 100, 100, 100, 100, 100), sx, sy, 0, 0, 0, 0);
        // vertical step: Gx=-800, Gy=0 -> 200; unshifted clips
        run("step200", w_r200, sx, sy, 200, 0, 255, 1);
        // ramp: Gx=-80, Gy=-240, sum 320
        run("ramp", w_mix, sx, sy, 80, 0, 255, 1);
        // worst case: 34425 on each axis, opposite signs
        run("worst", mk_w(255, 255, 255, 255, 255, 255, 255, 255, 255),
            k_fill(5'h0F), k_fill(5'h1F), 255, 1, 255, 1);
        // corner kernels, bright top row: Gx=0, Gy=7650
        run("corners", mk_w(255, 255, 255, 0, 0, 0, 0, 0, 0),
            mk_k(15, 0, -15, 0, 0, 0, 15, 0, -15), mk_k(15, 0, 15, 0, 0, 0, -15, 0, -15), 255, 1, 255, 1);
        // sum 1020 -> exactly 255 after shift, not clipped
        run("b1020", mk_w(255, 0, 0, 0, 0, 0, 0, 0, 0), mk_k(4, 0, 0, 0, 0, 0, 0, 0, 0), kz, 255, 0, 255, 1);
        // sum 1024 -> 256 after shift, clipped
        run("b1024", mk_w(128, 0, 0, 0, 0, 0, 0, 0, 0), mk_k(-8, 0, 0, 0, 0, 0, 0, 0, 0), kz, 255, 1, 255, 1);
        // sum 255: unshifted lands exactly on the limit
        run("b255", mk_w(0, 0, 0, 0, 51, 0, 0, 0, 0), kz, mk_k(0, 0, 0, 0, -5, 0, 0, 0, 0), 63, 0, 255, 0);
        // negative zero everywhere contributes nothing
        run("negzero", w_mix, knz, knz, 0, 0, 0, 0);

        // backpressure: result held for 20 cycles while new windows are offered
        out_ready = 1'b0;
        launch("bp", w_r200, sx, sy);
        wait_result("bp", 200, 0, 255, 1);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            win = mk_w(i, 9, 8, 7, 6, 5, 4, 3, 2);
            @(posedge clk); #1;
            check_eq("bp_hold", {28'd0, out_valid, in_ready, sat, 1'b0} | (32'(edge_out) << 4),
                     32'h0000_0C88);
        end
        in_valid = 1'b0;
        release_out("bp");
        check_eq("bp_edge_kept", 32'(edge_out), 32'd200);

        // reset in the middle of accumulation discards the window
        launch("midrst", w_mix, sx, sy);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_edge", 32'(edge_out), 32'd0);
        check_eq("midrst_sat", 32'(sat), 32'd0);
        run("after_rst", w_r100, sx, sy, 100, 0, 255, 1);

        // back-to-back windows with in_valid held high
        ws[0] = w_mix;  xs[0] = knz; ys[0] = knz;
        ws[1] = w_r200; xs[1] = sx;  ys[1] = sy;
        ws[2] = w_mix;  xs[2] = sx;  ys[2] = sy;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    win = ws[i]; kx = xs[i]; ky = ys[i]; in_valid = 1'b1;
                    dn = 0;
                    while (!in_ready && dn < 50) begin
                        @(posedge clk); #1; dn++;
                    end
                    @(posedge clk); #1;
                    acc_cyc[i] = cyc;
                end
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    mn = 0;
                    while (!out_valid && mn < 60) begin
                        @(posedge clk); #1; mn++;
                    end
                    res[i] = edge_out;
                    res_sat[i] = sat;
                    @(posedge clk); #1;
                end
            end
        join
        check_eq("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd11);
        check_eq("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd11);
        check_eq("b2b_res0", 32'(res[0]), 32'd0);
        check_eq("b2b_res1", 32'(res[1]), 32'd200);
        check_eq("b2b_res2", 32'(res[2]), 32'd80);
        check_eq("b2b_sats", {29'd0, res_sat[0], res_sat[1], res_sat[2]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
